// File: rtl/adder_unit.sv
// Registered half-adder, full-adder and WIDTH-bit ripple-carry adder paths
// sharing one operand strobe; all outputs are flops cleared by async reset.

module ha_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

// Full adder built from two half adders; the two partial carries never both set.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    ha_cell u_ha0 (.a(a),  .b(b),   .sum(s1),  .cout(c1));
    ha_cell u_ha1 (.a(s1), .b(cin), .sum(sum), .cout(c2));

    assign cout = c1 | c2;
endmodule

module rca_chain #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_cell u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
    assign ovf  = carry[WIDTH] ^ carry[WIDTH-1];
endmodule

module adder_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             ha_a,
    input  logic             ha_b,
    input  logic             fa_a,
    input  logic             fa_b,
    input  logic             fa_cin,
    input  logic [WIDTH-1:0] rca_a,
    input  logic [WIDTH-1:0] rca_b,
    input  logic             rca_cin,
    output logic             out_valid,
    output logic             ha_sum,
    output logic             ha_cout,
    output logic             fa_sum,
    output logic             fa_cout,
    output logic [WIDTH-1:0] rca_sum,
    output logic             rca_cout,
    output logic             rca_ovf
);
    logic             ha_sum_d;
    logic             ha_cout_d;
    logic             fa_sum_d;
    logic             fa_cout_d;
    logic [WIDTH-1:0] rca_sum_d;
    logic             rca_cout_d;
    logic             rca_ovf_d;

    ha_cell u_ha (
        .a    (ha_a),
        .b    (ha_b),
        .sum  (ha_sum_d),
        .cout (ha_cout_d)
    );

    fa_cell u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (fa_cin),
        .sum  (fa_sum_d),
        .cout (fa_cout_d)
    );

    rca_chain #(.WIDTH(WIDTH)) u_rca (
        .a    (rca_a),
        .b    (rca_b),
        .cin  (rca_cin),
        .sum  (rca_sum_d),
        .cout (rca_cout_d),
        .ovf  (rca_ovf_d)
    );

    // Results load only on a strobe and otherwise hold; out_valid marks the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ha_sum    <= 1'b0;
            ha_cout   <= 1'b0;
            fa_sum    <= 1'b0;
            fa_cout   <= 1'b0;
            rca_sum   <= '0;
            rca_cout  <= 1'b0;
            rca_ovf   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ha_sum   <= ha_sum_d;
                ha_cout  <= ha_cout_d;
                fa_sum   <= fa_sum_d;
                fa_cout  <= fa_cout_d;
                rca_sum  <= rca_sum_d;
                rca_cout <= rca_cout_d;
                rca_ovf  <= rca_ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_adder_unit.sv
// Scoreboard bench for adder_unit: directed vectors, reset, exhaustive and random
// stimulus against an arithmetic reference model.

module tb_adder_unit;
    localparam int W  = 4;
    localparam int EW = W + 7;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         ha_a, ha_b;
    logic         fa_a, fa_b, fa_cin;
    logic [W-1:0] rca_a, rca_b;
    logic         rca_cin;
    logic         out_valid;
    logic         ha_sum, ha_cout, fa_sum, fa_cout;
    logic [W-1:0] rca_sum;
    logic         rca_cout, rca_ovf;

    int checks;
    int errors;

    logic [EW-1:0] exp_q[$];
    logic [EW-2:0] held;
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] mon_act;

    adder_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .ha_a      (ha_a),
        .ha_b      (ha_b),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .rca_a     (rca_a),
        .rca_b     (rca_b),
        .rca_cin   (rca_cin),
        .out_valid (out_valid),
        .ha_sum    (ha_sum),
        .ha_cout   (ha_cout),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout),
        .rca_sum   (rca_sum),
        .rca_cout  (rca_cout),
        .rca_ovf   (rca_ovf)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // reference model: plain integer arithmetic
    function automatic logic [EW-2:0] model(input logic ha_x, ha_y, fa_x, fa_y, fa_c,
                                            input logic [W-1:0] a, b, input logic c);
        int unsigned total;
        int sa, sb, ss;
        logic [W-1:0] s;
        logic co, ov;
        total = int'(a) + int'(b) + int'(c);
        s  = W'(total % (1 << W));
        co = (total >= (1 << W));
        sa = (int'(a) >= (1 << (W-1))) ? int'(a) - (1 << W) : int'(a);
        sb = (int'(b) >= (1 << (W-1))) ? int'(b) - (1 << W) : int'(b);
        ss = sa + sb + int'(c);
        ov = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
        return {ha_x ^ ha_y, ha_x & ha_y,
                1'((int'(fa_x) + int'(fa_y) + int'(fa_c)) % 2),
                (int'(fa_x) + int'(fa_y) + int'(fa_c)) >= 2,
                s, co, ov};
    endfunction

    // driver: one clock cycle per call; expectation pushed at the sampling edge
    task automatic do_cycle(input logic r, input logic v, input logic [1:0] ha,
                            input logic [2:0] fa, input logic [W-1:0] a, b,
                            input logic c);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        {ha_a, ha_b} = ha;
        {fa_a, fa_b, fa_cin} = fa;
        rca_a    = a;
        rca_b    = b;
        rca_cin  = c;
        @(posedge clk);
        if (r) begin
            held = '0;
            exp_q.push_back('0);
        end else if (v) begin
            held = model(ha[1], ha[0], fa[2], fa[1], fa[0], a, b, c);
            exp_q.push_back({1'b1, held});
        end else begin
            exp_q.push_back({1'b0, held});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            do_cycle(1'b0, 1'b0, 2'($urandom), 3'($urandom), W'($urandom), W'($urandom),
                     1'($urandom));
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({out_valid, ha_sum, ha_cout, fa_sum, fa_cout, rca_sum, rca_cout, rca_ovf} != '0) begin
            errors++;
            $display("FAIL %s: outputs=%b required all zero", name,
                     {out_valid, ha_sum, ha_cout, fa_sum, fa_cout, rca_sum, rca_cout, rca_ovf});
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {out_valid, ha_sum, ha_cout, fa_sum, fa_cout, rca_sum, rca_cout, rca_ovf};
            checks++;
            if (mon_act[EW-1] !== mon_exp[EW-1]) begin
                errors++;
                $display("FAIL out_valid at %0t: got %b want %b", $time, mon_act[EW-1],
                         mon_exp[EW-1]);
            end
            checks++;
            if (mon_act[EW-2:0] !== mon_exp[EW-2:0]) begin
                errors++;
                $display("FAIL results at %0t: got ha=%b fa=%b sum=%h cout=%b ovf=%b want ha=%b fa=%b sum=%h cout=%b ovf=%b",
                         $time, mon_act[EW-2:EW-3], mon_act[EW-4:EW-5], mon_act[W+1:2],
                         mon_act[1], mon_act[0], mon_exp[EW-2:EW-3], mon_exp[EW-4:EW-5],
                         mon_exp[W+1:2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    // stimulus
    initial begin
        checks   = 0;
        errors   = 0;
        held     = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        {ha_a, ha_b, fa_a, fa_b, fa_cin, rca_cin} = '0;
        rca_a    = '0;
        rca_b    = '0;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // half-adder sweep
        for (int i = 0; i < 4; i++)
            do_cycle(1'b0, 1'b1, 2'(i), 3'b000, '0, '0, 1'b0);
        // full-adder vectors
        do_cycle(1'b0, 1'b1, 2'b00, 3'b000, '0, '0, 1'b0);
        do_cycle(1'b0, 1'b1, 2'b00, 3'b110, '0, '0, 1'b0);
        do_cycle(1'b0, 1'b1, 2'b00, 3'b111, '0, '0, 1'b0);
        // ripple-carry directed: plain, wrap with carry, signed overflow
        do_cycle(1'b0, 1'b1, 2'b00, 3'b000, 4'b0011, 4'b0011, 1'b0);
        do_cycle(1'b0, 1'b1, 2'b00, 3'b000, 4'b1111, 4'b0001, 1'b0);
        do_cycle(1'b0, 1'b1, 2'b00, 3'b000, 4'b0111, 4'b0001, 1'b0);
        do_cycle(1'b0, 1'b1, 2'b11, 3'b011, 4'b1000, 4'b1000, 1'b1);
        // hold: operands change while strobe is low
        do_cycle(1'b0, 1'b1, 2'b11, 3'b111, 4'b1111, 4'b0001, 1'b0);
        do_cycle(1'b0, 1'b0, 2'b01, 3'b001, 4'b0101, 4'b0010, 1'b1);
        do_cycle(1'b0, 1'b0, 2'b10, 3'b100, 4'b0011, 4'b0110, 1'b0);

        // reset between edges after a valid result
        do_cycle(1'b0, 1'b1, 2'b11, 3'b111, 4'b1111, 4'b1111, 1'b1);
        idle(1);
        #3;
        exp_q.delete();
        held = '0;
        rst  = 1'b1;
        #1;
        check_all_zero("async_reset");
        do_cycle(1'b1, 1'b1, 2'b11, 3'b111, 4'b1110, 4'b0011, 1'b1);
        do_cycle(1'b1, 1'b1, 2'b11, 3'b111, 4'b0111, 4'b0111, 1'b0);
        idle(3);

        // exhaustive ripple-carry stream, back-to-back
        for (int k = 0; k < 512; k++)
            do_cycle(1'b0, 1'b1, 2'($urandom), 3'($urandom), W'(k & 15), W'((k >> 4) & 15),
                     1'(k >> 8));

        // random traffic with gaps
        for (int k = 0; k < 300; k++)
            do_cycle(1'b0, ($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom),
                     W'($urandom), W'($urandom), 1'($urandom));

        // drain
        idle(2);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++)
            @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_unit.md
ADDER_UNIT -- requirements
Module: adder_unit

Interface
REQ-001 Parameter WIDTH, default 4, bit width of the ripple-carry adder operands and sum; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand strobe; all three adder inputs sampled on a rising clk edge when high.
REQ-005 ha_a  input  1  half-adder operand A.
REQ-006 ha_b  input  1  half-adder operand B.
REQ-007 fa_a  input  1  full-adder operand A.
REQ-008 fa_b  input  1  full-adder operand B.
REQ-009 fa_cin  input  1  full-adder carry-in.
REQ-010 rca_a  input  WIDTH  ripple-carry operand A, unsigned.
REQ-011 rca_b  input  WIDTH  ripple-carry operand B, unsigned.
REQ-012 rca_cin  input  1  ripple-carry carry-in into bit 0.
REQ-013 out_valid  output  1  high for one cycle when registered results update.
REQ-014 ha_sum  output  1  registered half-adder sum.
REQ-015 ha_cout  output  1  registered half-adder carry.
REQ-016 fa_sum  output  1  registered full-adder sum.
REQ-017 fa_cout  output  1  registered full-adder carry.
REQ-018 rca_sum  output  WIDTH  registered ripple-carry sum.
REQ-019 rca_cout  output  1  registered carry out of bit WIDTH-1.
REQ-020 rca_ovf  output  1  registered signed overflow flag (two's-complement view of operands).

Function
REQ-021 Half-adder path SHALL compute sum = a XOR b, cout = a AND b.
REQ-022 Full-adder path SHALL compute sum = a XOR b XOR cin, cout = majority(a, b, cin).
REQ-023 Ripple-carry path SHALL be a chain of WIDTH full-adder cells, bit 0 carry-in = rca_cin, carry of bit i feeding bit i+1.
REQ-024 {rca_cout, rca_sum} SHALL equal rca_a + rca_b + rca_cin computed in WIDTH+1 bits, no saturation; results wrap modulo 2^WIDTH with carry in rca_cout.
REQ-025 rca_ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-026 Latency SHALL be exactly one cycle: results of operands sampled at edge N appear on outputs after edge N.
REQ-027 out_valid SHALL be high for the cycle following every edge at which in_valid was high, else low; back-to-back in_valid gives continuous out_valid.
REQ-028 When in_valid is low at an edge, all result outputs SHALL hold their previous values.
REQ-029 The three paths SHALL be independent; inputs of one path SHALL not affect outputs of another.
REQ-030 Outputs SHALL be driven only from registers (no combinational input-to-output path).

Reset
REQ-031 While rst is high, all outputs (out_valid, ha_*, fa_*, rca_sum, rca_cout, rca_ovf) SHALL be 0, asynchronously, independent of clk.
REQ-032 rst asserted mid-operation SHALL discard any pending sample; first out_valid after release SHALL follow the first in_valid edge after rst deasserts.

Verification
REQ-033 HA sweep: (a,b) = 00,01,10,11 with in_valid -> next cycle (sum,cout) = 00,10,10,01.
REQ-034 FA: (a,b,cin) = 000 -> (sum,cout)=(0,0); 110 -> (0,1); 111 -> (1,1); out_valid=1 each following cycle.
REQ-035 RCA WIDTH=4: 0011+0011+0 -> sum 0110, cout 0, ovf 0; 1111+0001+0 -> sum 0000, cout 1, ovf 0; 0111+0001+0 -> sum 1000, cout 0, ovf 1.
REQ-036 Hold: apply 1111+0001 with in_valid, then change operands with in_valid low -> outputs stay 0000/1, out_valid 0.
REQ-037 Reset: assert rst between clk edges after valid result -> all outputs 0 immediately; release, no in_valid -> outputs remain 0.
REQ-038 Exhaustive: all 512 combinations of rca_a, rca_b, rca_cin at WIDTH=4 streamed back-to-back -> each result matches a+b+cin one cycle later.
